// File: rtl/exp4_condiciona_entradas.sv
// Input conditioning ahead of the experiment top level: synchronizes and debounces
// the start button and the switch bank. Macro BOTAO_ATIVO_BAIXO_EN selects an active-low button.
module exp4_condiciona_entradas #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned N_CHAVES        = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                botao_iniciar,
   input  logic [N_CHAVES-1:0] chaves_raw,
   output logic                iniciar,
   output logic [N_CHAVES-1:0] chaves,
   output logic                jogada,
   output logic                db_botao,
   output logic [3:0]          db_estado
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // The synchronizer carries the raw pin level, so its reset value is the released level.
`ifdef BOTAO_ATIVO_BAIXO_EN
   localparam logic BTN_REPOUSO = 1'b1;
`else
   localparam logic BTN_REPOUSO = 1'b0;
`endif

   typedef enum logic [1:0] {
      OCIOSO       = 2'd0,
      FILTRA_ALTA  = 2'd1,
      PRESSIONADO  = 2'd2,
      FILTRA_BAIXA = 2'd3
   } estado_t;

   logic                r_btn_s1, r_btn_s2;
   logic [N_CHAVES-1:0] r_ch_s1, r_ch_s2;
   logic                w_btn;

   estado_t             r_estado, w_estado_prox;
   logic [CNT_W-1:0]    r_cnt, w_cnt_prox;
   logic                w_iniciar_prox;

   logic [N_CHAVES-1:0] r_cand, w_cand_prox, w_chaves_prox;
   logic [CNT_W-1:0]    r_cnt_c, w_cnt_c_prox;
   logic                w_jogada_prox;

   // Two-flop synchronizers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_btn_s1 <= BTN_REPOUSO;
         r_btn_s2 <= BTN_REPOUSO;
         r_ch_s1  <= '0;
         r_ch_s2  <= '0;
      end else begin
         r_btn_s1 <= botao_iniciar;
         r_btn_s2 <= r_btn_s1;
         r_ch_s1  <= chaves_raw;
         r_ch_s2  <= r_ch_s1;
      end
   end

   assign w_btn = r_btn_s2 ^ BTN_REPOUSO;

   // Button debounce FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado <= OCIOSO;
         r_cnt    <= '0;
         iniciar  <= 1'b0;
      end else begin
         r_estado <= w_estado_prox;
         r_cnt    <= w_cnt_prox;
         iniciar  <= w_iniciar_prox;
      end
   end

   always_comb begin
      w_estado_prox  = r_estado;
      w_cnt_prox     = r_cnt;
      w_iniciar_prox = 1'b0;
      case (r_estado)
         OCIOSO: begin
            if (w_btn) begin
               w_estado_prox = FILTRA_ALTA;
               w_cnt_prox    = '0;
            end
         end
         FILTRA_ALTA: begin
            if (!w_btn) begin
               w_estado_prox = OCIOSO;
            end else if (r_cnt == CNT_MAX) begin
               w_estado_prox  = PRESSIONADO;
               w_iniciar_prox = 1'b1;
            end else begin
               w_cnt_prox = r_cnt + CNT_W'(1);
            end
         end
         PRESSIONADO: begin
            if (!w_btn) begin
               w_estado_prox = FILTRA_BAIXA;
               w_cnt_prox    = '0;
            end
         end
         FILTRA_BAIXA: begin
            // A return to pressed here is a release bounce, never a new press
            if (w_btn) begin
               w_estado_prox = PRESSIONADO;
            end else if (r_cnt == CNT_MAX) begin
               w_estado_prox = OCIOSO;
            end else begin
               w_cnt_prox = r_cnt + CNT_W'(1);
            end
         end
         default: w_estado_prox = OCIOSO;
      endcase
   end

   // Switch word filter: any change restarts the count from the new candidate
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cand  <= '0;
         r_cnt_c <= '0;
         chaves  <= '0;
         jogada  <= 1'b0;
      end else begin
         r_cand  <= w_cand_prox;
         r_cnt_c <= w_cnt_c_prox;
         chaves  <= w_chaves_prox;
         jogada  <= w_jogada_prox;
      end
   end

   always_comb begin
      w_cand_prox   = r_cand;
      w_cnt_c_prox  = r_cnt_c;
      w_chaves_prox = chaves;
      w_jogada_prox = 1'b0;
      if ((r_ch_s2 == chaves) || (r_ch_s2 != r_cand)) begin
         w_cand_prox  = r_ch_s2;
         w_cnt_c_prox = '0;
      end else if (r_cnt_c == CNT_MAX) begin
         w_chaves_prox = r_cand;
         w_jogada_prox = (r_cand != '0);
      end else begin
         w_cnt_c_prox = r_cnt_c + CNT_W'(1);
      end
   end

   assign db_botao  = w_btn;
   assign db_estado = {2'b00, r_estado};

endmodule

// File: tb/tb_exp4_condiciona_entradas.sv
// Scoreboard bench for exp4_condiciona_entradas with DEBOUNCE_CYCLES=4.
module tb_exp4_condiciona_entradas;

   localparam int unsigned D = 4;
   localparam int unsigned N = 4;
`ifdef BOTAO_ATIVO_BAIXO_EN
   localparam logic ON  = 1'b0;
   localparam logic OFF = 1'b1;
`else
   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic         botao_iniciar;
   logic [N-1:0] chaves_raw;
   logic         iniciar;
   logic [N-1:0] chaves;
   logic         jogada;
   logic         db_botao;
   logic [3:0]   db_estado;

   exp4_condiciona_entradas #(.DEBOUNCE_CYCLES(D), .N_CHAVES(N)) dut (
      .clock(clock), .reset(reset), .botao_iniciar(botao_iniciar), .chaves_raw(chaves_raw),
      .iniciar(iniciar), .chaves(chaves), .jogada(jogada), .db_botao(db_botao),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   int           exp_ini[$];
   int           exp_jog[$];
   int           exp_ch_cyc[$];
   logic [N-1:0] exp_ch_val[$];
   logic [N-1:0] prev_ch = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event at cycle %0d, required none", name, cyc);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clock);
   endtask

   // Monitor: every output event pops the scoreboard
   always @(negedge clock) begin
      if (reset) begin
         prev_ch = chaves;
      end else begin
         if (iniciar) begin
            if (exp_ini.size() == 0) unexpected("iniciar");
            else check("iniciar_cycle", cyc, exp_ini.pop_front());
         end
         if (jogada) begin
            if (exp_jog.size() == 0) unexpected("jogada");
            else check("jogada_cycle", cyc, exp_jog.pop_front());
         end
         if (chaves !== prev_ch) begin
            if (exp_ch_cyc.size() == 0) unexpected("chaves_change");
            else begin
               check("chaves_cycle", cyc, exp_ch_cyc.pop_front());
               check("chaves_value", 32'(chaves), 32'(exp_ch_val.pop_front()));
            end
            prev_ch = chaves;
         end
      end
   end

   initial begin
      int e;
      int r;
      reset         = 1'b1;
      botao_iniciar = OFF;
      chaves_raw    = '0;
      repeat (3) @(negedge clock);
      check("rst_iniciar", 32'(iniciar), 0);
      check("rst_jogada", 32'(jogada), 0);
      check("rst_chaves", 32'(chaves), 0);
      check("rst_estado", 32'(db_estado), 0);
      check("rst_db_botao", 32'(db_botao), 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // Clean press, held 40 cycles, then release
      botao_iniciar = ON;
      e = cyc + 1;
      exp_ini.push_back(e + 6);
      wait_to(e + 1); check("t1_db_botao", 32'(db_botao), 1);
      wait_to(e + 2); check("t1_estado_fa", 32'(db_estado), 1);
      wait_to(e + 5); check("t1_estado_fa_end", 32'(db_estado), 1);
      wait_to(e + 6); check("t1_estado_press", 32'(db_estado), 2);
      wait_to(e + 40);
      botao_iniciar = OFF;
      e = cyc + 1;
      wait_to(e + 2); check("t1_estado_fb", 32'(db_estado), 3);
      wait_to(e + 5); check("t1_estado_fb_end", 32'(db_estado), 3);
      wait_to(e + 6); check("t1_estado_idle", 32'(db_estado), 0);
      repeat (4) @(negedge clock);

      // Bouncing press 1,0,1,0 then stable high
      botao_iniciar = ON;  @(negedge clock);
      botao_iniciar = OFF; @(negedge clock);
      botao_iniciar = ON;  @(negedge clock);
      botao_iniciar = OFF; @(negedge clock);
      botao_iniciar = ON;
      e = cyc + 1;
      exp_ini.push_back(e + 6);
      wait_to(e + 6); check("t2_estado_press", 32'(db_estado), 2);
      wait_to(e + 15);
      botao_iniciar = OFF;
      repeat (10) @(negedge clock);

      // Switch 0000->0100, then back to 0000 without jogada
      chaves_raw = 4'b0100;
      e = cyc + 1;
      exp_ch_cyc.push_back(e + 6); exp_ch_val.push_back(4'b0100);
      exp_jog.push_back(e + 6);
      wait_to(e + 12);
      chaves_raw = 4'b0000;
      e = cyc + 1;
      exp_ch_cyc.push_back(e + 6); exp_ch_val.push_back(4'b0000);
      wait_to(e + 12);

      // 0010 for two cycles, then 0001 stable
      chaves_raw = 4'b0010;
      repeat (2) @(negedge clock);
      chaves_raw = 4'b0001;
      e = cyc + 1;
      exp_ch_cyc.push_back(e + 6); exp_ch_val.push_back(4'b0001);
      exp_jog.push_back(e + 6);
      wait_to(e + 12);

      // Glitch returning to the current value: no update
      chaves_raw = 4'b0011;
      repeat (2) @(negedge clock);
      chaves_raw = 4'b0001;
      repeat (15) @(negedge clock);
      check("t4_chaves_hold", 32'(chaves), 1);

      // Reset while filtering a press (cnt=2), button held through reset
      botao_iniciar = ON;
      e = cyc + 1;
      wait_to(e + 4);
      check("t5_estado_pre", 32'(db_estado), 1);
      reset = 1'b1;
      @(negedge clock);
      check("t5_iniciar", 32'(iniciar), 0);
      check("t5_jogada", 32'(jogada), 0);
      check("t5_chaves", 32'(chaves), 0);
      check("t5_estado", 32'(db_estado), 0);
      @(negedge clock);
      reset = 1'b0;
      r = cyc;
      exp_ini.push_back(r + 7);
      exp_ch_cyc.push_back(r + 7); exp_ch_val.push_back(4'b0001);
      exp_jog.push_back(r + 7);
      wait_to(r + 12);
      botao_iniciar = OFF;
      chaves_raw    = 4'b0000;
      e = cyc + 1;
      exp_ch_cyc.push_back(e + 6); exp_ch_val.push_back(4'b0000);
      wait_to(e + 12);

      // Drain scoreboard with a bounded wait
      for (int k = 0; k < 50; k++) begin
         if (exp_ini.size() == 0 && exp_jog.size() == 0 && exp_ch_cyc.size() == 0) break;
         @(negedge clock);
      end
      while (exp_ini.size() != 0) begin
         checks++; errors++;
         $display("FAIL iniciar_missing: no pulse, required at cycle %0d", exp_ini.pop_front());
      end
      while (exp_jog.size() != 0) begin
         checks++; errors++;
         $display("FAIL jogada_missing: no pulse, required at cycle %0d", exp_jog.pop_front());
      end
      while (exp_ch_cyc.size() != 0) begin
         checks++; errors++;
         $display("FAIL chaves_missing: no change, required %0d at cycle %0d",
                  exp_ch_val.pop_front(), exp_ch_cyc.pop_front());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
